dsconv_bn_sequencer: RTL and testbench



---
 rtl/dsconv_pkg.sv | 25 ++
 rtl/dsconv_bn_apply.sv | 36 +++
 rtl/dsconv_bn_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dsconv_bn_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dsconv_pkg.sv
// Shared widths and state encoding for the dsconv batch-norm path.
// The field widths must match the batch-normalization weight memory.
package dsconv_pkg;

    localparam int P_W     = 18;
    localparam int Q_W     = 36;
    localparam int X_W     = 18;
    localparam int LAYER_W = 3;
    localparam int FILT_W  = 4;
    localparam int N_FILT  = 16;

    // p*x fits in P_W+X_W bits; one extra bit keeps p*x+q from overflowing
    localparam int PROD_W  = P_W + X_W;
    localparam int ACC_W   = PROD_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } bn_seq_state_t;

endpackage

// File: rtl/dsconv_bn_apply.sv
// Combinational batch-norm datapath: y = ReLU(sat((p*x + q) >>> SHIFT)).
// The caller registers o_y.
module dsconv_bn_apply
    import dsconv_pkg::*;
#(
    parameter int SHIFT = 12,
    parameter int OUT_W = 8
) (
    input  logic signed [P_W-1:0] i_p,
    input  logic signed [Q_W-1:0] i_q,
    input  logic signed [X_W-1:0] i_x,
    output logic        [OUT_W-1:0] o_y
);

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << OUT_W) - 1);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_sh;

    assign w_prod = i_p * i_x;
    assign w_acc  = $signed({w_prod[PROD_W-1], w_prod}) + $signed({{(ACC_W-Q_W){i_q[Q_W-1]}}, i_q});
    assign w_sh   = w_acc >>> SHIFT;

    always_comb begin
        o_y = '0;
        if (w_sh[ACC_W-1]) begin
            o_y = '0;
        end else if (w_sh > Y_MAX) begin
            o_y = '1;
        end else begin
            o_y = w_sh[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dsconv_bn_sequencer.sv
// Walks filters 0..N_FILT-1 of one dsconv layer, fetching (p, q) per filter
// and streaming each channel's activations through dsconv_bn_apply.
module dsconv_bn_sequencer
    import dsconv_pkg::*;
#(
    parameter int PIX_PER_CH = 64,
    parameter int SHIFT      = 12,
    parameter int OUT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LAYER_W-1:0]        layer_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      wmem_start,
    output logic [LAYER_W-1:0]        wmem_layer_sel,
    output logic [FILT_W-1:0]         wmem_filter_sel,
    input  logic signed [P_W-1:0]     wmem_p,
    input  logic signed [Q_W-1:0]     wmem_q,
    input  logic                      wmem_ready,
    input  logic                      x_valid,
    input  logic signed [X_W-1:0]     x_data,
    output logic                      x_ready,
    output logic                      y_valid,
    output logic [OUT_W-1:0]          y_data,
    output logic [FILT_W-1:0]         y_ch,
    output logic                      y_last,
    input  logic                      y_ready
);

    localparam int                 PIX_W     = (PIX_PER_CH > 1) ? $clog2(PIX_PER_CH) : 1;
    localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(PIX_PER_CH - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(N_FILT - 1);

    bn_seq_state_t            r_state;
    logic [LAYER_W-1:0]       r_layer;
    logic [FILT_W-1:0]        r_filt;
    logic [PIX_W-1:0]         r_pix;
    logic signed [P_W-1:0]    r_p;
    logic signed [Q_W-1:0]    r_q;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_wmem_start;
    logic                     r_y_valid;
    logic [OUT_W-1:0]         r_y_data;
    logic [FILT_W-1:0]        r_y_ch;
    logic                     r_y_last;

    logic                     w_x_ready;
    logic                     w_x_fire;
    logic                     w_last_pix;
    logic                     w_last_filt;
    logic [OUT_W-1:0]         w_y;

    dsconv_bn_apply #(
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_apply (
        .i_p (r_p),
        .i_q (r_q),
        .i_x (x_data),
        .o_y (w_y)
    );

    // Single output slot: accept a new x whenever the slot is empty or being drained
    assign w_x_ready   = (r_state == STREAM) && (!r_y_valid || y_ready);
    assign w_x_fire    = x_valid && w_x_ready;
    assign w_last_pix  = (r_pix == PIX_LAST);
    assign w_last_filt = (r_filt == FILT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_layer      <= '0;
            r_filt       <= '0;
            r_pix        <= '0;
            r_p          <= '0;
            r_q          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wmem_start <= 1'b0;
            r_y_valid    <= 1'b0;
            r_y_data     <= '0;
            r_y_ch       <= '0;
            r_y_last     <= 1'b0;
        end else begin
            // The output slot drains independently of the FSM, so a previous
            // channel's y can still leave during FETCH/LOAD with its own y_ch.
            if (w_x_fire) begin
                r_y_valid <= 1'b1;
                r_y_data  <= w_y;
                r_y_ch    <= r_filt;
                r_y_last  <= w_last_pix && w_last_filt;
            end else if (y_ready) begin
                r_y_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_layer      <= layer_sel;
                        r_filt       <= '0;
                        r_pix        <= '0;
                        r_busy       <= 1'b1;
                        r_wmem_start <= 1'b1;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    r_wmem_start <= 1'b0;
                    r_state      <= LOAD;
                end
                LOAD: begin
                    // Memory answers one cycle after its start strobe; ready is sticky
                    if (wmem_ready) begin
                        r_p     <= wmem_p;
                        r_q     <= wmem_q;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_x_fire) begin
                        if (w_last_pix) begin
                            r_pix <= '0;
                            if (w_last_filt) begin
                                r_state <= DRAIN;
                            end else begin
                                r_filt       <= r_filt + 1'b1;
                                r_wmem_start <= 1'b1;
                                r_state      <= FETCH;
                            end
                        end else begin
                            r_pix <= r_pix + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_y_valid || y_ready) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign wmem_start      = r_wmem_start;
    assign wmem_layer_sel  = r_layer;
    assign wmem_filter_sel = r_filt;
    assign x_ready         = w_x_ready;
    assign y_valid         = r_y_valid;
    assign y_data          = r_y_data;
    assign y_ch            = r_y_ch;
    assign y_last          = r_y_last;

endmodule

// File: tb/tb_dsconv_bn_sequencer.sv
// Directed bench for dsconv_bn_sequencer with a 1-cycle-latency weight memory model.
module tb_dsconv_bn_sequencer;

    localparam int PIX   = 4;
    localparam int NTOT  = PIX * 16;
    localparam int SHIFT = 12;
    localparam int OUT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [2:0]         layer_sel;
    logic               busy, done;
    logic               wmem_start;
    logic [2:0]         wmem_layer_sel;
    logic [3:0]         wmem_filter_sel;
    logic signed [17:0] wmem_p = '0;
    logic signed [35:0] wmem_q = '0;
    logic               wmem_ready = 1'b0;
    logic               x_valid;
    logic signed [17:0] x_data;
    logic               x_ready;
    logic               y_valid;
    logic [OUT_W-1:0]   y_data;
    logic [3:0]         y_ch;
    logic               y_last;
    logic               y_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int xv [NTOT];

    dsconv_bn_sequencer #(
        .PIX_PER_CH (PIX),
        .SHIFT      (SHIFT),
        .OUT_W      (OUT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .layer_sel       (layer_sel),
        .busy            (busy),
        .done            (done),
        .wmem_start      (wmem_start),
        .wmem_layer_sel  (wmem_layer_sel),
        .wmem_filter_sel (wmem_filter_sel),
        .wmem_p          (wmem_p),
        .wmem_q          (wmem_q),
        .wmem_ready      (wmem_ready),
        .x_valid         (x_valid),
        .x_data          (x_data),
        .x_ready         (x_ready),
        .y_valid         (y_valid),
        .y_data          (y_data),
        .y_ch            (y_ch),
        .y_last          (y_last),
        .y_ready         (y_ready)
    );

    always #5 clk = ~clk;

    function automatic int ptab(input int l, input int f);
        if (l == 0 && f == 0) return 236;
        if (l == 7 && f == 10) return 0;
        return 50 + 13 * f + 7 * l;
    endfunction

    function automatic longint qtab(input int l, input int f);
        if (l == 0 && f == 0) return -239327;
        if (l == 7 && f == 10) return 471;
        return -40000 + 9000 * f - 3000 * l;
    endfunction

    function automatic int model(input int p, input longint q, input int x);
        longint a;
        a = longint'(p) * longint'(x) + q;
        a = a >>> SHIFT;
        if (a < 0) return 0;
        if (a > 255) return 255;
        return int'(a);
    endfunction

    // Weight memory: data valid the cycle after wmem_start, ready sticky once set
    always @(posedge clk) begin
        if (wmem_start) begin
            wmem_p     <= 18'(ptab(int'(wmem_layer_sel), int'(wmem_filter_sel)));
            wmem_q     <= 36'(qtab(int'(wmem_layer_sel), int'(wmem_filter_sel)));
            wmem_ready <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wstart"}, wmem_start, 0);
        chk({tag, "_wlayer"}, wmem_layer_sel, 0);
        chk({tag, "_wfilt"}, wmem_filter_sel, 0);
        chk({tag, "_xready"}, x_ready, 0);
        chk({tag, "_yvalid"}, y_valid, 0);
        chk({tag, "_ydata"}, y_data, 0);
        chk({tag, "_ych"}, y_ch, 0);
        chk({tag, "_ylast"}, y_last, 0);
    endtask

    // One layer pass. bp_at/glitch_at/abort_at are input indices (-1 = unused).
    task automatic run_pass(input int layer, input int bp_at, input int glitch_at, input int abort_at);
        int idx, nout, nst, bp_left, last_fire, exp_y, f;
        bit bp_used, finished, fire_x;
        logic [OUT_W-1:0] hold_d;
        logic [3:0]       hold_ch;
        idx = 0; nout = 0; nst = 0; bp_left = 0; last_fire = -10;
        bp_used = 0; finished = 0; hold_d = '0; hold_ch = '0;
        @(negedge clk);
        start = 1'b1; layer_sel = 3'(layer);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            x_valid = (idx < NTOT);
            x_data  = 18'(xv[(idx < NTOT) ? idx : 0]);
            if (bp_at >= 0 && !bp_used && idx >= bp_at && y_valid) begin
                bp_left = 5; bp_used = 1; hold_d = y_data; hold_ch = y_ch;
            end
            y_ready = (bp_left == 0);
            if (glitch_at >= 0 && idx == glitch_at) begin
                start = 1'b1; layer_sel = 3'(layer ^ 5);
            end else begin
                start = 1'b0;
            end
            #1;
            if (abort_at >= 0 && idx >= abort_at && wmem_filter_sel == 4'd5) begin
                chk("abort_in_stream", y_valid, 1);
                rst_n = 1'b0;
                #1;
                chk_idle_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1; x_valid = 1'b0; y_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk); #1;
                    chk("no_done_after_rst", done, 0);
                end
                return;
            end
            if (bp_left > 0) begin
                chk("bp_xready", x_ready, 0);
                chk("bp_ydata_hold", y_data, hold_d);
                chk("bp_ych_hold", y_ch, hold_ch);
                bp_left--;
            end
            if (wmem_start) begin
                chk("wmem_filter_sel", wmem_filter_sel, nst);
                chk("wmem_layer_sel", wmem_layer_sel, layer);
                nst++;
            end
            if (done) begin
                chk("done_timing", cyc, last_fire + 1);
                chk("busy_in_done", busy, 0);
                finished = 1;
            end
            if (y_valid && y_ready) begin
                if (nout < NTOT) begin
                    f = nout / PIX;
                    exp_y = model(ptab(layer, f), qtab(layer, f), xv[nout]);
                    chk("y_data", y_data, exp_y);
                    chk("y_ch", y_ch, f);
                    chk("y_last", y_last, (nout == NTOT - 1));
                    if (layer == 0 && nout == 0) chk("hand_x2048", y_data, 59);
                    if (layer == 0 && nout == 1) chk("hand_x0", y_data, 0);
                    if (layer == 0 && nout == 2) chk("hand_xmax", y_data, 255);
                    if (layer == 7 && f == 10) chk("hand_l7f10", y_data, 0);
                end
                nout++;
                last_fire = cyc;
            end
            fire_x = x_valid && x_ready;
            @(posedge clk);
            if (fire_x) idx++;
        end
        x_valid = 1'b0;
        chk("pass_finished", finished, 1);
        chk("out_count", nout, NTOT);
        chk("wmem_start_count", nst, 16);
        @(negedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("layer_latched", wmem_layer_sel, layer);
    endtask

    initial begin
        for (int i = 0; i < NTOT; i++) xv[i] = i * 1237 - 20000;
        xv[0] = 2048; xv[1] = 0; xv[2] = 131071;
        rst_n = 1'b0; start = 1'b0; layer_sel = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(0, -1, -1, -1);
        run_pass(7, 18, 30, -1);
        run_pass(2, -1, -1, 21);
        run_pass(1, 50, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
